// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line idle level, counter width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic TXD_IDLE = 1'b1;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_tick.sv
// Rising-edge detector for a slow level sampled in the clk_in domain; tick is combinational
// from the input, one cycle wide. History flop resets high so a high level at release gives no tick.
module edge_tick (
    input  logic clk_in,
    input  logic reset,
    input  logic i_sig,
    output logic o_tick
);

    logic r_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b1;
        end else begin
            r_q <= i_sig;
        end
    end

    assign o_tick = i_sig & ~r_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: one-entry holding buffer (valid/ready) feeding a start/data/parity/stop
// shifter; txd is registered and moves one cycle after each baud tick; tx_ready = buffer empty.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy
);

    localparam int             CW       = cnt_w(DATA_BITS);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_BITS - 1);

    logic                 w_tick;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_last_stop;
    tx_state_e            r_state,   w_state_nxt;
    logic                 r_txd,     w_txd_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic [CW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic                 r_stop_cnt, w_stop_cnt_nxt;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic                 r_par;

    edge_tick u_baud_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .i_sig  (baud_clk),
        .o_tick (w_tick)
    );

    assign w_accept    = tx_valid & ~r_hold_full;
    assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;

    always_comb begin
        w_state_nxt    = r_state;
        w_txd_nxt      = r_txd;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_load         = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    w_load = r_hold_full;
                end
                START: begin
                    w_state_nxt   = DATA;
                    w_txd_nxt     = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = '0;
                end
                DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_stop_cnt_nxt = 1'b0;
                        if (PARITY_EN != 0) begin
                            w_state_nxt = PARITY;
                            w_txd_nxt   = r_par;
                        end else begin
                            w_state_nxt = STOP;
                            w_txd_nxt   = TXD_IDLE;
                        end
                    end else begin
                        w_txd_nxt     = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    w_state_nxt    = STOP;
                    w_txd_nxt      = TXD_IDLE;
                    w_stop_cnt_nxt = 1'b0;
                end
                STOP: begin
                    if (!w_last_stop) begin
                        w_stop_cnt_nxt = 1'b1;
                    end else if (r_hold_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_txd_nxt   = TXD_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_txd_nxt   = TXD_IDLE;
                end
            endcase
            // Loading from the buffer always opens a new frame with the start bit.
            if (w_load) begin
                w_state_nxt = START;
                w_txd_nxt   = 1'b0;
                w_shift_nxt = r_hold;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_txd      <= TXD_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_txd      <= w_txd_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
        end
    end

    // Accept and load are exclusive: accept needs the buffer empty, load needs it full.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_par       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
                r_par       <= (^r_hold) ^ (PARITY_ODD != 0);
            end
        end
    end

    assign tx_ready = ~r_hold_full;
    assign txd      = r_txd;
    assign busy     = (r_state != IDLE) | r_hold_full;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (8N1, 8O2, 8E1), a UART line decoder per instance
// checking frames against a queue of expected bytes, plus directed timing checks.
module tb_uart_tx_frame;

    typedef struct packed {
        logic [7:0] d;
        logic       b2b;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       baud_clk = 1'b1;
    bit         baud_en  = 1'b0;
    int         bcnt     = 8;
    int         cyc      = 0;
    int         n_pass   = 0;
    int         n_total  = 0;

    logic [7:0] dat    [3];
    logic       vld    [3];
    logic       rdy    [3];
    logic       txd_w  [3];
    logic       busy_w [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk_in(clk), .reset(rst_n), .baud_clk(baud_clk), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .txd(txd_w[0]), .busy(busy_w[0]));

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut1 (
        .clk_in(clk), .reset(rst_n), .baud_clk(baud_clk), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .txd(txd_w[1]), .busy(busy_w[1]));

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut2 (
        .clk_in(clk), .reset(rst_n), .baud_clk(baud_clk), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .txd(txd_w[2]), .busy(busy_w[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Baud level: 16-cycle period, updated on the falling clk edge.
    initial begin
        forever begin
            @(negedge clk);
            if (baud_en) begin
                bcnt     = (bcnt + 1) % 16;
                baud_clk = (bcnt >= 8);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit pen(input int idx);
        return idx != 0;
    endfunction

    function automatic bit podd(input int idx);
        return idx == 1;
    endfunction

    function automatic int nstop(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    function automatic int flen(input int idx);
        return 1 + 8 + int'(pen(idx)) + nstop(idx);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_exp(input int idx, input exp_t e);
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int idx, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        case (idx)
            0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Line decoder: samples each bit mid-period after a falling edge on an idle line.
    task automatic monitor(input int idx);
        logic [7:0] d;
        logic       p;
        int         ts;
        int         tprev;
        bit         ok;
        exp_t       e;
        tprev = -100000;
        forever begin
            @(negedge clk);
            if (rst_n && txd_w[idx] == 1'b0) begin
                ts = cyc;
                repeat (8) @(negedge clk);
                chk($sformatf("dut%0d_start_bit", idx), int'(txd_w[idx]), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    d[i] = txd_w[idx];
                end
                p = 1'b0;
                if (pen(idx)) begin
                    repeat (16) @(negedge clk);
                    p = txd_w[idx];
                end
                for (int s = 0; s < nstop(idx); s++) begin
                    repeat (16) @(negedge clk);
                    chk($sformatf("dut%0d_stop_bit%0d", idx, s), int'(txd_w[idx]), 1);
                end
                pop_exp(idx, e, ok);
                chk($sformatf("dut%0d_frame_expected", idx), int'(ok), 1);
                if (ok) begin
                    chk($sformatf("dut%0d_data", idx), int'(d), int'(e.d));
                    if (pen(idx))
                        chk($sformatf("dut%0d_parity", idx), int'(p), int'((^e.d) ^ podd(idx)));
                    if (e.b2b)
                        chk($sformatf("dut%0d_b2b_spacing", idx), ts - tprev, flen(idx) * 16);
                end
                tprev = ts;
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
    end

    task automatic send(input int idx, input logic [7:0] d, input bit push, input bit b2b);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        dat[idx] = d;
        vld[idx] = 1'b1;
        while (!rdy[idx] && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!rdy[idx]) begin
            chk($sformatf("dut%0d_send_ready_timeout", idx), int'(rdy[idx]), 1);
            vld[idx] = 1'b0;
            return;
        end
        if (push) begin
            e.d   = d;
            e.b2b = b2b;
            push_exp(idx, e);
        end
        @(posedge clk);
        #1;
        vld[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx);
        int n;
        n = 0;
        while (busy_w[idx] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d_idle_reached", idx), int'(busy_w[idx]), 0);
    endtask

    initial begin
        int n;
        int n_txd;
        int n_rdy;
        int n_nbusy;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h00;
        end

        // Reset with baud held high, then 100 quiet cycles.
        repeat (5) @(negedge clk);
        chk("rst_txd", int'(txd_w[0]), 1);
        chk("rst_ready", int'(rdy[0]), 1);
        chk("rst_busy", int'(busy_w[0]), 0);
        rst_n = 1'b1;
        n_txd = 0; n_rdy = 0; n_nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_txd   += int'(txd_w[0] & txd_w[1] & txd_w[2]);
            n_rdy   += int'(rdy[0] & rdy[1] & rdy[2]);
            n_nbusy += int'(!busy_w[0] && !busy_w[1] && !busy_w[2]);
        end
        chk("post_rst_txd_high_cycles", n_txd, 100);
        chk("post_rst_ready_cycles", n_rdy, 100);
        chk("post_rst_notbusy_cycles", n_nbusy, 100);
        baud_en = 1'b1;

        // 8N1 0x55: busy falls exactly ten bit times after start.
        send(0, 8'h55, 1'b1, 1'b0);
        n = 0;
        while (txd_w[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t2_start_seen", int'(txd_w[0]), 0);
        n = 0;
        while (busy_w[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t2_busy_fall_cycles", n, 160);
        chk("t2_txd_after_frame", int'(txd_w[0]), 1);

        // 0xA3 then 0x0F with valid held: second accept right after first load.
        wait_idle(0);
        send(0, 8'hA3, 1'b1, 1'b0);
        send(0, 8'h0F, 1'b1, 1'b1);
        chk("t3_txd_at_second_accept", int'(txd_w[0]), 0);
        n = 0;
        while (!rdy[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t3_ready_low_cycles", n, 160);
        chk("t3_txd_at_ready_return", int'(txd_w[0]), 0);

        // Valid coincident with a tick while idle: start waits for the next tick.
        wait_idle(0);
        @(posedge baud_clk);
        dat[0] = 8'hC6;
        vld[0] = 1'b1;
        push_exp(0, '{d: 8'hC6, b2b: 1'b0});
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        n = 0;
        while (txd_w[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_start_delay", n, 17);

        // Parity odd + 2 stop, parity even + 1 stop, each followed by a back-to-back frame.
        wait_idle(0);
        fork
            begin
                send(1, 8'h07, 1'b1, 1'b0);
                send(1, 8'h5A, 1'b1, 1'b1);
            end
            begin
                send(2, 8'h07, 1'b1, 1'b0);
                send(2, 8'h5A, 1'b1, 1'b1);
            end
        join
        wait_idle(1);
        wait_idle(2);
        repeat (40) @(negedge clk);

        // Reset during data bit 3 of 0xFF with a second byte buffered.
        wait_idle(0);
        send(0, 8'hFF, 1'b1, 1'b0);
        send(0, 8'h3C, 1'b0, 1'b0);
        chk("t6_ready_low_buffered", int'(rdy[0]), 0);
        repeat (70) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_txd", int'(txd_w[0]), 1);
        chk("t6_async_ready", int'(rdy[0]), 1);
        chk("t6_async_busy", int'(busy_w[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after_release", int'(rdy[0]), 1);
        repeat (400) @(negedge clk);
        chk("t6_txd_quiet", int'(txd_w[0]), 1);
        chk("t6_busy_quiet", int'(busy_w[0]), 0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
